// File: rtl/fault_campaign_ctrl.sv
// ---------------------------------------------------------------------------
// fault_campaign_ctrl
//
// Sequencer for a stuck-at fault campaign on an N_IN-input OR gate. It drives
// one pattern bus shared by an external golden gate and an external faulty
// gate. It injects each single stuck-at fault in turn and sweeps the input
// patterns. It compares the two gate outputs and hands one result record per
// fault out through a valid/ready interface.
//
// Fault index f runs 0..NUM_FAULTS-1. Site is f>>1 (0..N_IN-1 = input i,
// N_IN = gate output) and the stuck value is f[0].
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      campaign start request (only looked at while idle)
//   busy       high while a campaign is in progress (SETUP..REPORT)
//   done       one-cycle pulse at the end of a campaign
//   pat        pattern to both gate instances, pat[i] drives input i
//   flt_en     fault injection enable for the faulty instance
//   flt_site   injected fault site
//   flt_val    injected stuck value (0 = SA0, 1 = SA1)
//   good_o     golden gate output
//   bad_o      faulty gate output
//   res_valid  result record valid
//   res_ready  result record accepted
//   res_fault  fault index of the record
//   res_det    fault was detected
//   res_pat    first detecting pattern (0 if undetected)
//   res_cnt    number of detecting patterns
//   det_total  running count of detected faults in this campaign
//
// Optional build macro:
//   FAULT_DROP_EN - stop a fault's sweep at its first mismatch (fault
//                   dropping); detected faults then report res_cnt = 1.
// ---------------------------------------------------------------------------
module fault_campaign_ctrl #(
   parameter  int N_IN       = 2,
   localparam int SITE_W     = $clog2(N_IN + 1),
   localparam int NUM_FAULTS = 2 * (N_IN + 1),
   localparam int FLT_W      = $clog2(NUM_FAULTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [N_IN-1:0]   pat,
   output logic              flt_en,
   output logic [SITE_W-1:0] flt_site,
   output logic              flt_val,
   input  logic              good_o,
   input  logic              bad_o,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [FLT_W-1:0]  res_fault,
   output logic              res_det,
   output logic [N_IN-1:0]   res_pat,
   output logic [N_IN:0]     res_cnt,
   output logic [FLT_W:0]    det_total
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_APPLY,
      S_SAMPLE,
      S_REPORT,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [FLT_W-1:0]   fault_idx;
   logic [N_IN-1:0]    pat_r;
   logic               det_r;
   logic [N_IN-1:0]    first_pat_r;
   logic [N_IN:0]      cnt_r;
   logic [FLT_W:0]     det_total_r;

   logic               mism;
   logic               last_pat;
   logic               last_fault;
   logic               handshake;
   logic               sweep_end;

   assign mism       = good_o ^ bad_o;
   assign last_pat   = &pat_r;
   assign last_fault = (fault_idx == FLT_W'(NUM_FAULTS - 1));
   assign handshake  = (state == S_REPORT) && res_ready;

   // The sweep for the current fault normally ends on the all-ones pattern,
   // so the pattern counter never wraps. With fault dropping, the first
   // mismatch also ends it.
`ifdef FAULT_DROP_EN
   assign sweep_end = last_pat || mism;
`else
   assign sweep_end = last_pat;
`endif

   // State register. Reset is synchronous, so a reset mid-campaign drops
   // back to IDLE on the next edge without producing a partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. Each pattern costs an APPLY (settle) cycle and a
   // SAMPLE cycle. REPORT waits for the consumer before moving on.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_SETUP;
         S_SETUP:  state_nxt = S_APPLY;
         S_APPLY:  state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = sweep_end ? S_REPORT : S_APPLY;
         S_REPORT: begin
            if (res_ready) begin
               state_nxt = last_fault ? S_DONE : S_SETUP;
            end
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers. The per-fault result registers and the pattern are
   // cleared on every transition into SETUP, so they are already zero during
   // the SETUP cycle. det_total is cleared on start and otherwise holds
   // after DONE until the next campaign.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_idx   <= '0;
         pat_r       <= '0;
         det_r       <= 1'b0;
         first_pat_r <= '0;
         cnt_r       <= '0;
         det_total_r <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  fault_idx   <= '0;
                  det_total_r <= '0;
                  pat_r       <= '0;
                  det_r       <= 1'b0;
                  first_pat_r <= '0;
                  cnt_r       <= '0;
               end
            end
            S_SAMPLE: begin
               if (mism) begin
                  cnt_r <= cnt_r + (N_IN + 1)'(1);
                  if (!det_r) begin
                     det_r       <= 1'b1;
                     first_pat_r <= pat_r;
                  end
               end
               if (!sweep_end) begin
                  pat_r <= pat_r + N_IN'(1);
               end
            end
            S_REPORT: begin
               if (handshake) begin
                  det_total_r <= det_total_r + (FLT_W + 1)'(det_r);
                  if (!last_fault) begin
                     fault_idx   <= fault_idx + FLT_W'(1);
                     pat_r       <= '0;
                     det_r       <= 1'b0;
                     first_pat_r <= '0;
                     cnt_r       <= '0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Control outputs are pure functions of the state.
   always_comb begin
      busy      = 1'b0;
      flt_en    = 1'b0;
      done      = 1'b0;
      res_valid = 1'b0;
      unique case (state)
         S_SETUP, S_APPLY, S_SAMPLE: begin
            busy   = 1'b1;
            flt_en = 1'b1;
         end
         S_REPORT: begin
            busy      = 1'b1;
            flt_en    = 1'b1;
            res_valid = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: begin
         end
      endcase
   end

   // Data outputs are forced to zero outside the states that own them. This
   // keeps the pattern bus and fault port quiet while idle or done, and it
   // keeps the result fields at zero whenever res_valid is low.
   assign pat       = flt_en ? pat_r : '0;
   assign flt_site  = flt_en ? fault_idx[FLT_W-1:1] : '0;
   assign flt_val   = flt_en ? fault_idx[0] : 1'b0;
   assign res_fault = res_valid ? fault_idx : '0;
   assign res_det   = res_valid ? det_r : 1'b0;
   assign res_pat   = res_valid ? first_pat_r : '0;
   assign res_cnt   = res_valid ? cnt_r : '0;
   assign det_total = det_total_r;

endmodule
